// File: rtl/iob_regfile_mp.sv
// Multi-read-port byte-strobed register file with registered, write-first reads
// and a one-register-per-cycle hardware clear sweep.
module iob_regfile_mp #(
    parameter  int N      = 16,
    parameter  int W      = 32,
    parameter  int NR     = 2,
    localparam int ADDR_W = $clog2(N),
    localparam int STRB_W = W / 8
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 cke_i,
    input  logic                 clr_i,
    output logic                 busy_o,
    input  logic                 wen_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [STRB_W-1:0]    wstrb_i,
    input  logic [W-1:0]         wdata_i,
    input  logic [NR-1:0]        ren_i,
    input  logic [NR*ADDR_W-1:0] raddr_i,
    output logic [NR*W-1:0]      rdata_o,
    output logic [NR-1:0]        rvalid_o
);

    typedef enum logic [0:0] {
        IDLE_S  = 1'b0,
        CLEAR_S = 1'b1
    } state_t;

    // Counter carries one extra bit so that N == 2**ADDR_W still has a reachable last index.
    localparam logic [ADDR_W:0] N_EXT   = N[ADDR_W:0];
    localparam logic [ADDR_W:0] N_LAST  = N_EXT - {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [W-1:0] byte_merge(
        input logic [W-1:0]      old_v,
        input logic [W-1:0]      new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [W-1:0] res;
        res = old_v;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [W-1:0]         mem_q [N];
    logic [W-1:0]         mem_d [N];
    state_t               state_q, state_d;
    logic [ADDR_W:0]      cnt_q, cnt_d;
    logic [NR-1:0][W-1:0] rdata_q, rdata_d;
    logic [NR-1:0]        rvalid_q, rvalid_d;
    logic                 wr_hit_s;

    assign wr_hit_s = wen_i && (state_q == IDLE_S) && ({1'b0, waddr_i} < N_EXT);

    // Storage update, clear sweep and FSM next state.
    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cke_i) begin
            case (state_q)
                IDLE_S: begin
                    // A write in the clear-accept cycle still lands; the sweep overwrites it later.
                    if (wr_hit_s) begin
                        mem_d[waddr_i] = byte_merge(mem_q[waddr_i], wdata_i, wstrb_i);
                    end else begin
                        mem_d = mem_q;
                    end
                    if (clr_i) begin
                        state_d = CLEAR_S;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE_S;
                    end
                end
                CLEAR_S: begin
                    mem_d[cnt_q[ADDR_W-1:0]] = '0;
                    if (cnt_q == N_LAST) begin
                        state_d = IDLE_S;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_S;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Read ports sample the post-write array, which gives the byte-merged write-first bypass.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        for (int p = 0; p < NR; p++) begin
            if (cke_i) begin
                if (ren_i[p] && (state_q == IDLE_S)) begin
                    rvalid_d[p] = 1'b1;
                    if ({1'b0, raddr_i[p*ADDR_W +: ADDR_W]} < N_EXT) begin
                        rdata_d[p] = mem_d[raddr_i[p*ADDR_W +: ADDR_W]];
                    end else begin
                        rdata_d[p] = '0;
                    end
                end else begin
                    rvalid_d[p] = 1'b0;
                end
            end else begin
                rvalid_d[p] = rvalid_q[p];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            state_q  <= IDLE_S;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            mem_q    <= mem_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign busy_o   = (state_q == CLEAR_S);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_iob_regfile_mp.sv
// Directed self-checking bench for iob_regfile_mp (N=16 main instance, N=12 range instance).
module tb_iob_regfile_mp;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cke;
    logic        clr;
    logic        wen;
    logic [3:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  ren;
    logic [7:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        busy;
    logic [63:0] rdata12;
    logic [1:0]  rvalid12;
    logic        busy12;

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    iob_regfile_mp #(.N(16), .W(32), .NR(2)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .clr_i(clr), .busy_o(busy),
        .wen_i(wen), .waddr_i(waddr), .wstrb_i(wstrb), .wdata_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid)
    );

    iob_regfile_mp #(.N(12), .W(32), .NR(2)) dut12 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .clr_i(clr), .busy_o(busy12),
        .wen_i(wen), .waddr_i(waddr), .wstrb_i(wstrb), .wdata_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata12), .rvalid_o(rvalid12)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd_chk(input int p, input logic [3:0] a, input logic [31:0] exp, input string tag);
        ren = 2'b00;
        ren[p] = 1'b1;
        raddr[p*4 +: 4] = a;
        @(negedge clk);
        chk({tag, " rvalid"}, 64'(rvalid[p]), 64'd1);
        chk(tag, 64'(rdata[p*32 +: 32]), 64'(exp));
        ren = 2'b00;
    endtask

    // Back-to-back reads on both ports; every register expected zero.
    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            ren   = 2'b11;
            raddr = {4'(i), 4'(i)};
            @(negedge clk);
            chk({tag, " rvalid"}, 64'(rvalid), 64'd3);
            chk({tag, " rdata"}, rdata, 64'd0);
        end
        ren = 2'b00;
        @(negedge clk);
        chk({tag, " rvalid end"}, 64'(rvalid), 64'd0);
    endtask

    // Pulse clr and count busy cycles while hammering ignored traffic; optional cke stall.
    task automatic clear_run(input int stall_at, input int stall_len, input logic [63:0] hold,
                             output int cycles);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (stall_len > 0 && cycles == stall_at) cke = 1'b0;
            if (stall_len > 0 && cycles == stall_at + stall_len) cke = 1'b1;
            wen = 1'b1; waddr = 4'd2; wdata = 32'h5555_5555; wstrb = 4'hF;
            ren = 2'b11; raddr = 8'h22; clr = 1'b1;
            @(negedge clk);
            chk("busy rvalid", 64'(rvalid), 64'd0);
            chk("busy rdata hold", rdata, hold);
        end
        wen = 1'b0; ren = 2'b00; clr = 1'b0; cke = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0; cke = 1'b1; clr = 1'b0; wen = 1'b0; waddr = 4'd0;
        wstrb = 4'd0; wdata = 32'd0; ren = 2'b00; raddr = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst rvalid", 64'(rvalid), 64'd0);
        chk("rst rdata", rdata, 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // 1: all registers zero after reset, consecutive valid pulses
        read_all_zero("t1");
        chk("t1 busy", 64'(busy), 64'd0);

        // 2: full write, then low-byte update, then zero-strobe write is a no-op
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        wr(4'd3, 32'h0000_00AA, 4'h1);
        rd_chk(0, 4'd3, 32'hDEAD_BEAA, "t2 merge");
        wr(4'd3, 32'h0000_0000, 4'h0);
        rd_chk(0, 4'd3, 32'hDEAD_BEAA, "t2 nostrb");

        // 3: same-cycle write and dual read of reg 5 sees merged data
        wr(4'd5, 32'hFFFF_FFFF, 4'hF);
        wen = 1'b1; waddr = 4'd5; wdata = 32'h1234_5678; wstrb = 4'h3;
        ren = 2'b11; raddr = 8'h55;
        @(negedge clk);
        wen = 1'b0; ren = 2'b00;
        chk("t3 rvalid", 64'(rvalid), 64'd3);
        chk("t3 bypass", rdata, {32'hFFFF_5678, 32'hFFFF_5678});
        rd_chk(1, 4'd5, 32'hFFFF_5678, "t3 stored");

        // 4: fill, clear, exactly 16 busy cycles with traffic ignored
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), {8'hA5, 8'(i), 16'h0F0F}, 4'hF);
        end
        ren = 2'b11; raddr = 8'h77;
        @(negedge clk);
        ren = 2'b00;
        chk("t4 fill", rdata, {32'hA507_0F0F, 32'hA507_0F0F});
        clear_run(0, 0, {32'hA507_0F0F, 32'hA507_0F0F}, cyc);
        chk("t4 busy cycles", 64'(cyc), 64'd16);
        read_all_zero("t4");

        // 5: clear with a 5-cycle cke stall at counter 7
        wr(4'd0, 32'h0000_0001, 4'hF);
        wr(4'd10, 32'h1010_1010, 4'hF);
        clear_run(8, 5, 64'd0, cyc);
        chk("t5 busy cycles", 64'(cyc), 64'd21);
        rd_chk(0, 4'd10, 32'd0, "t5 reg10");

        // 5b: reset part way through a clear
        wr(4'd12, 32'hABCD_0012, 4'hF);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 busy mid", 64'(busy), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("t5 rst busy", 64'(busy), 64'd0);
        chk("t5 rst rdata", rdata, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        read_all_zero("t5 post");

        // 6: N=12 instance drops write to 13 and returns zero for 14
        chk("t6 busy12", 64'(busy12), 64'd0);
        wr(4'd13, 32'hCAFE_F00D, 4'hF);
        wr(4'd1, 32'h0000_0011, 4'hF);
        ren = 2'b01; raddr = 8'h0E;
        @(negedge clk);
        ren = 2'b00;
        chk("t6 oob rvalid", 64'(rvalid12[0]), 64'd1);
        chk("t6 oob rdata", 64'(rdata12[31:0]), 64'd0);
        for (int i = 0; i < 12; i++) begin
            ren = 2'b10; raddr = {4'(i), 4'd0};
            @(negedge clk);
            chk("t6 rvalid12", 64'(rvalid12[1]), 64'd1);
            chk("t6 reg12", 64'(rdata12[63:32]), (i == 1) ? 64'h11 : 64'd0);
        end
        ren = 2'b00;
        rd_chk(0, 4'd13, 32'hCAFE_F00D, "t6 n16 reg13");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iob_regfile_mp.md
Name: iob_regfile_mp

Overview:
Multi-read-port, byte-strobed register file. It is the generalised successor of the 2-port register file and supports:
- a configurable number of read ports;
- registered reads with write-to-read bypass;
- a sequential hardware clear engine.

It sits next to CPU-facing control/status logic and per-channel configuration stores wherever several consumers must read the same register bank in one cycle.

Parameters:
N, 16, number of registers (>=2).
W, 32, register width in bits; must be a multiple of 8.
NR, 2, number of independent read ports (>=1).
ADDR_W, $clog2(N), address width (derived; do not override).
STRB_W, W/8, write strobe width (derived).

Ports:
clk_i  input  1  clock, posedge.
arst_n_i  input  1  asynchronous reset, active-low.
cke_i  input  1  clock enable; low freezes all state, including FSM, counter, registers and outputs.
clr_i  input  1  request to clear all registers to 0 (pulse).
busy_o  output  1  high while the clear engine runs.
wen_i  input  1  write enable.
waddr_i  input  ADDR_W  write register index.
wstrb_i  input  STRB_W  byte strobes; bit k enables wdata_i[8k+:8].
wdata_i  input  W  write data.
ren_i  input  NR  per-port read enable.
raddr_i  input  NR*ADDR_W  port p address at [p*ADDR_W+:ADDR_W].
rdata_o  output  NR*W  port p data at [p*W+:W].
rvalid_o  output  NR  per-port read-data valid pulse.

Behaviour:
Reset (arst_n_i low, asynchronous):
- all N registers = 0;
- rdata_o = 0, rvalid_o = 0, busy_o = 0;
- FSM = IDLE, clear counter = 0.
- Release is synchronous to clk_i.

Write (all gated by cke_i):
- Happens on the edge where wen_i=1, busy_o=0 and waddr_i<N.
- Only strobed bytes of register waddr_i update; unstrobed bytes are kept.
- wstrb_i=0 leaves the register unchanged.
- waddr_i>=N: write is dropped silently.

Read:
- Latency 1 cycle: on the edge where ren_i[p]=1 and busy_o=0, rdata_o[p] loads the register at raddr_i[p] and rvalid_o[p]=1 for the next cycle.
- rvalid_o[p] is a single-cycle pulse per accepted read; back-to-back reads give consecutive pulses.
- rdata_o[p] holds its last value until the next accepted read on port p.
- raddr_i[p]>=N returns 0 with rvalid_o[p]=1.
- Ports are fully independent. Any number of ports may read the same address in the same cycle, and all see identical data.

Write-read collision:
- A read accepted in the same cycle as a write to the same address returns the post-write value (write-first bypass).
- Bypass is byte-merged: strobed bytes come from wdata_i, the rest from the stored value.

Clear FSM:
- States IDLE and CLEAR.
- IDLE to CLEAR: clr_i=1 while IDLE. busy_o goes 1 from the next cycle and the counter starts at 0.
- In CLEAR: one register per cycle is written to 0, at address = counter, then the counter increments.
- CLEAR to IDLE: after register N-1 is cleared. The clear is exactly N cycles; busy_o falls on the cycle after the last clear write.
- While busy_o=1:
  - wen_i and ren_i are ignored; rvalid_o stays 0;
  - clr_i is ignored (no restart);
  - rdata_o holds its value.
- A write in the same cycle that clr_i is accepted in IDLE still commits, then is overwritten by the sweep.
- cke_i=0 during CLEAR stalls the counter; the clear resumes where it stopped.
- Reset mid-clear: immediate return to IDLE, all registers 0.

Width rules:
- Address compares are unsigned at full ADDR_W; no wrap-around on out-of-range addresses.
- The counter is ADDR_W+1 bits so that N equal to a power of two terminates correctly.

Test Plan:
1. Reset, then read all N addresses on both ports -> every rdata_o=0, rvalid_o pulses 1 cycle after each ren_i, busy_o=0.
2. Write 0xDEADBEEF to reg 3 with wstrb=4'hF, then 0x000000AA with wstrb=4'h1 -> port0 reads 0xDEADBEAA one cycle after ren_i.
3. Same cycle: write 0x12345678 wstrb=4'h3 to reg 5 (old 0xFFFFFFFF) while port0 and port1 both read reg 5 -> both return 0xFFFF5678.
4. Fill regs with nonzero values, pulse clr_i -> busy_o high for exactly 16 cycles; writes and reads issued during that window are ignored (rvalid_o=0); afterwards all regs read 0.
5. Start clear, drop cke_i for 5 cycles at counter=7 -> busy_o lasts 21 cycles total; then deassert arst_n_i mid-clear -> busy_o=0 immediately, all regs 0.
6. N=12: write to waddr=13 and read raddr=14 -> no register changes, rdata_o=0 with rvalid_o=1.
